// File: rtl/wb_mem_stage.sv
// wb_mem_stage: final pipeline stage. Returns ALU results to decode as
// register write-backs and runs load/store transactions against data memory.
// While a memory transaction is outstanding the stage sits in MEM_WAIT and
// holds the execute stage through ex_stall.
//
// Memory handshake: dmem_req is raised together with dmem_we/dmem_addr/
// dmem_wdata and all four are held stable until a single-cycle dmem_ack.
// A transaction completes in the cycle dmem_ack is high; read data is
// sampled from dmem_rdata in that same cycle. dmem_ack seen in IDLE is ignored.
module wb_mem_stage #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [0:5]        ex_function_bit,
    input  logic [0:4]        ex_rD,
    input  logic [0:4]        ex_PPPWW,
    input  logic [0:63]       ex_result,
    input  logic [0:63]       ex_store_data,
    input  logic              ex_WB_en,
    input  logic              ex_wmem_en,
    output logic              ex_stall,
    output logic              ALU_WB_en,
    output logic [0:4]        WB_rD,
    output logic [0:4]        WB_PPPWW,
    output logic [0:63]       WB_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [0:ADDR_W-1] dmem_addr,
    output logic [0:63]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [0:63]       dmem_rdata,
    output logic              mem_err,
    output logic [0:31]       retired
);

    // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_next;
    logic             pend_load;
    logic [0:4]       pend_rD;
    logic [0:4]       pend_PPPWW;

    logic is_alu;
    logic is_load;
    logic is_store;
    logic start_mem;
    logic timeout_hit;

    // Op-class decode and transaction start/abort conditions.
    always_comb begin
        is_alu       = (ex_function_bit[0:1] == 2'b00);
        is_load      = (ex_function_bit == 6'b010000);
        is_store     = (ex_function_bit == 6'b100000) && ex_wmem_en;
        start_mem    = (state == IDLE) && ex_valid && (is_load || is_store);
        tmo_cnt_next = tmo_cnt + CNT_W'(1);
        // Fires in the TIMEOUT-th MEM_WAIT cycle; an ack in that cycle wins.
        timeout_hit  = (TIMEOUT != 0) && (state == MEM_WAIT) && !dmem_ack &&
                       (tmo_cnt_next == TMO_VAL);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_mem) state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ack || timeout_hit) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM outputs: the stall is a direct view of the state.
    always_comb begin
        ex_stall = (state == MEM_WAIT);
    end

    // Registered datapath: write-back port, memory port, error flag, retire count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_WB_en  <= 1'b0;
            WB_rD      <= '0;
            WB_PPPWW   <= '0;
            WB_data    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_err    <= 1'b0;
            retired    <= '0;
            tmo_cnt    <= '0;
            pend_load  <= 1'b0;
            pend_rD    <= '0;
            pend_PPPWW <= '0;
        end else begin
            ALU_WB_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid && is_alu) begin
                        retired <= retired + 32'd1;
                        if (ex_WB_en) begin
                            ALU_WB_en <= 1'b1;
                            WB_rD     <= ex_rD;
                            WB_PPPWW  <= ex_PPPWW;
                            WB_data   <= ex_result;
                        end
                    end
                    if (start_mem) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= ex_result[64-ADDR_W:63];
                        if (is_store) dmem_wdata <= ex_store_data;
                        pend_load  <= is_load;
                        pend_rD    <= ex_rD;
                        pend_PPPWW <= ex_PPPWW;
                        tmo_cnt    <= '0;
                    end
                end
                MEM_WAIT: begin
                    tmo_cnt <= tmo_cnt_next;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        retired  <= retired + 32'd1;
                        if (pend_load) begin
                            ALU_WB_en <= 1'b1;
                            WB_rD     <= pend_rD;
                            WB_PPPWW  <= pend_PPPWW;
                            WB_data   <= dmem_rdata;
                        end
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
